tx_serial_seq: RTL and testbench

TX_SERIAL_SEQ -- requirements
Module: tx_serial_seq

---
 rtl/tx_serial_seq_if.sv | 22 ++
 rtl/tx_serial_seq.sv | 132 +++++++++++++
 tb/tb_tx_serial_seq.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_serial_seq_if.sv
// Parallel-load / transmit handshake bundle between the memory-side controller and tx_serial_seq.
interface tx_serial_seq_if #(
    parameter int DATA_W = 8
);
    logic              PARALLEL_LOAD;
    logic [DATA_W-1:0] DIN;
    logic              Tx_DATA;
    logic              Tx_DONE;
    logic              TX_BUSY;
    logic              TX_OUT;
    logic              LOAD_IGN;

    modport master (
        output PARALLEL_LOAD, DIN, Tx_DATA,
        input  Tx_DONE, TX_BUSY, TX_OUT, LOAD_IGN
    );

    modport slave (
        input  PARALLEL_LOAD, DIN, Tx_DATA,
        output Tx_DONE, TX_BUSY, TX_OUT, LOAD_IGN
    );
endinterface

// File: rtl/tx_serial_seq.sv
// Serial transmitter: captures a parallel word, then sends start bit, DATA_W bits LSB first, stop bit.
// state   | meaning
// S_IDLE  | line high, ready; loads accepted, Tx_DATA rising edge starts a frame
// S_START | start bit (0) for BAUD_DIV cycles
// S_DATA  | payload bits LSB first, BAUD_DIV cycles each
// S_STOP  | stop bit (1) for BAUD_DIV cycles
module tx_serial_seq #(
    parameter int DATA_W   = 8,
    parameter int BAUD_DIV = 4
) (
    input  logic           CLK,
    input  logic           RESET,
    tx_serial_seq_if.slave bus
);
    localparam int BCW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BTW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
    localparam logic [BTW-1:0] BIT_LAST  = BTW'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_shift;
    logic [BCW-1:0]    r_baud;
    logic [BTW-1:0]    r_bit;
    logic              r_tx_q;
    logic              r_tx_out;
    logic              r_done;
    logic              r_busy;
    logic              r_load_ign;

    state_t            w_state_nxt;
    logic [DATA_W-1:0] w_hold_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [BCW-1:0]    w_baud_nxt;
    logic [BTW-1:0]    w_bit_nxt;
    logic              w_tx_out_nxt;
    logic              w_load_ign_nxt;
    logic              w_rise;
    logic              w_baud_wrap;

    assign w_rise      = bus.Tx_DATA & ~r_tx_q;
    assign w_baud_wrap = (r_baud == BAUD_LAST);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_hold     <= '0;
            r_shift    <= '0;
            r_baud     <= '0;
            r_bit      <= '0;
            r_tx_q     <= 1'b0;
            r_tx_out   <= 1'b1;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_load_ign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold     <= w_hold_nxt;
            r_shift    <= w_shift_nxt;
            r_baud     <= w_baud_nxt;
            r_bit      <= w_bit_nxt;
            r_tx_q     <= bus.Tx_DATA;
            r_tx_out   <= w_tx_out_nxt;
            r_done     <= (w_state_nxt == S_IDLE);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_load_ign <= w_load_ign_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_hold_nxt     = r_hold;
        w_shift_nxt    = r_shift;
        w_baud_nxt     = r_baud;
        w_bit_nxt      = r_bit;
        w_load_ign_nxt = bus.PARALLEL_LOAD & (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                if (bus.PARALLEL_LOAD) w_hold_nxt = bus.DIN;
                if (w_rise) begin
                    w_state_nxt = S_START;
                    // a load in the same cycle as the start edge wins over the old holding value
                    w_shift_nxt = bus.PARALLEL_LOAD ? bus.DIN : r_hold;
                end
            end
            S_START: begin
                w_baud_nxt = r_baud + 1'b1;
                if (w_baud_wrap) begin
                    w_state_nxt = S_DATA;
                    w_baud_nxt  = '0;
                end
            end
            S_DATA: begin
                w_baud_nxt = r_baud + 1'b1;
                if (w_baud_wrap) begin
                    w_baud_nxt = '0;
                    if (r_bit == BIT_LAST) begin
                        w_state_nxt = S_STOP;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = r_shift >> 1;
                    end
                end
            end
            S_STOP: begin
                w_baud_nxt = r_baud + 1'b1;
                if (w_baud_wrap) begin
                    w_state_nxt = S_IDLE;
                    w_baud_nxt  = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // line value is registered from the next state so each bit lasts exactly BAUD_DIV cycles
        case (w_state_nxt)
            S_START: w_tx_out_nxt = 1'b0;
            S_DATA:  w_tx_out_nxt = w_shift_nxt[0];
            default: w_tx_out_nxt = 1'b1;
        endcase
    end

    assign bus.TX_OUT   = r_tx_out;
    assign bus.Tx_DONE  = r_done;
    assign bus.TX_BUSY  = r_busy;
    assign bus.LOAD_IGN = r_load_ign;
endmodule

// File: tb/tb_tx_serial_seq.sv
// Scoreboard bench for tx_serial_seq: a frame-level model queues expected frames, a monitor checks the line.
module tb_tx_serial_seq;
    localparam int W     = 8;
    localparam int B     = 4;
    localparam int FRAME = (W + 2) * B;

    typedef struct {
        logic [W-1:0] data;
        int           start;
    } exp_t;

    logic CLK;
    logic RESET;
    tx_serial_seq_if #(.DATA_W(W)) bus ();

    tx_serial_seq #(.DATA_W(W), .BAUD_DIV(B)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    exp_t expq[$];

    // model state: remaining busy edges, holding word, last Tx_DATA sample
    int           m_cnt = 0;
    logic [W-1:0] m_hold = '0;
    logic         m_prev = 1'b0;
    int           m_ign = 0;
    int           frames_exp = 0;
    int           frames_seen = 0;
    int           ign_seen = 0;
    int           idle_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [FRAME-1:0] frame_wave(input logic [W-1:0] d);
        logic [FRAME-1:0] w;
        for (int i = 0; i < FRAME; i++) begin
            int slot;
            slot = i / B;
            if (slot == 0)          w[i] = 1'b0;
            else if (slot == W + 1) w[i] = 1'b1;
            else                    w[i] = d[slot-1];
        end
        return w;
    endfunction

    task automatic model_edge();
        if (m_cnt > 0) begin
            if (bus.PARALLEL_LOAD) m_ign++;
            m_cnt--;
        end else begin
            if (bus.PARALLEL_LOAD) m_hold = bus.DIN;
            if (bus.Tx_DATA && !m_prev) begin
                expq.push_back('{data: m_hold, start: cyc + 1});
                m_cnt = FRAME;
                frames_exp++;
            end
        end
        m_prev = bus.Tx_DATA;
    endtask

    task automatic drive(input logic ld, input logic [W-1:0] d, input logic t);
        bus.PARALLEL_LOAD = ld;
        bus.DIN           = d;
        bus.Tx_DATA       = t;
        model_edge();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle(input int n, input logic t);
        for (int i = 0; i < n; i++) drive(1'b0, '0, t);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_tx_out"},   64'(bus.TX_OUT),   64'd1);
        chk({tag, "_tx_done"},  64'(bus.Tx_DONE),  64'd1);
        chk({tag, "_tx_busy"},  64'(bus.TX_BUSY),  64'd0);
        chk({tag, "_load_ign"}, 64'(bus.LOAD_IGN), 64'd0);
    endtask

    // called just after a falling edge; reset is asserted between clock edges
    task automatic do_reset(input string tag, input logic t);
        bus.PARALLEL_LOAD = 1'b0;
        bus.Tx_DATA       = t;
        #2;
        RESET = 1'b1;
        #1;
        reset_checks(tag);
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        if (m_cnt > 0) frames_exp--;
        m_cnt  = 0;
        m_hold = '0;
        m_prev = 1'b0;
    endtask

    // frame monitor
    initial begin
        logic             prev_done;
        logic [FRAME-1:0] obs;
        logic             aborted;
        logic             have_exp;
        int               low_bad;
        int               start_cyc;
        exp_t             e;
        prev_done = 1'b1;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                prev_done = 1'b1;
                continue;
            end
            if (prev_done && !bus.Tx_DONE) begin
                start_cyc = cyc;
                have_exp  = (expq.size() > 0);
                if (have_exp) e = expq.pop_front();
                else chk("unexpected_frame", 64'(1), 64'(0));
                aborted = 1'b0;
                low_bad = 0;
                obs     = '0;
                for (int i = 0; i < FRAME; i++) begin
                    if (i > 0) @(negedge CLK);
                    if (RESET) begin
                        aborted = 1'b1;
                        break;
                    end
                    obs[i] = bus.TX_OUT;
                    if (bus.Tx_DONE !== 1'b0 || bus.TX_BUSY !== 1'b1) low_bad++;
                end
                if (!aborted) begin
                    @(negedge CLK);
                    if (!RESET) begin
                        frames_seen++;
                        chk("done_low_40_cycles", 64'(low_bad), 64'd0);
                        chk("done_back_high", 64'(bus.Tx_DONE), 64'd1);
                        if (have_exp) begin
                            chk("frame_wave", 64'(obs), 64'(frame_wave(e.data)));
                            chk("frame_start_cycle", 64'(start_cyc), 64'(e.start));
                        end
                    end
                end
            end
            prev_done = RESET ? 1'b1 : bus.Tx_DONE;
        end
    end

    // idle line level, busy/done complement and ignored-load pulse count
    initial begin
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                if (bus.Tx_DONE && bus.TX_OUT !== 1'b1) idle_bad++;
                if (bus.TX_BUSY === bus.Tx_DONE) idle_bad++;
                if (bus.LOAD_IGN) ign_seen++;
            end
        end
    end

    initial begin
        logic         t;
        logic         ld;
        logic [W-1:0] d;
        RESET = 1'b0;
        bus.PARALLEL_LOAD = 1'b0;
        bus.DIN = '0;
        bus.Tx_DATA = 1'b0;
        #1 RESET = 1'b1;
        #1 reset_checks("por");
        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        // load 0xA5, then a one-cycle transmit pulse
        drive(1'b1, 8'hA5, 1'b0);
        drive(1'b0, '0, 1'b1);
        idle(45, 1'b0);

        // load coincident with start edge, holding register cleared first
        do_reset("rst_a", 1'b0);
        drive(1'b1, 8'h3C, 1'b1);
        idle(45, 1'b0);

        // Tx_DATA held high for 100 cycles gives one frame only
        drive(1'b1, 8'h96, 1'b0);
        idle(100, 1'b1);
        idle(5, 1'b0);

        // load during DATA is ignored and the holding word survives
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b0, '0, 1'b1);
        idle(12, 1'b0);
        drive(1'b1, 8'hFF, 1'b0);
        idle(40, 1'b0);
        drive(1'b0, '0, 1'b1);
        idle(45, 1'b0);

        // back-to-back: new edge in the first idle cycle after the frame
        drive(1'b1, 8'h66, 1'b1);
        idle(FRAME, 1'b0);
        drive(1'b1, 8'hC3, 1'b1);
        idle(45, 1'b0);

        // reset at cycle 15 of a frame, then a clean 0x0F frame
        drive(1'b1, 8'h5A, 1'b1);
        idle(14, 1'b0);
        do_reset("rst_mid", 1'b0);
        drive(1'b1, 8'h0F, 1'b1);
        idle(45, 1'b0);

        // Tx_DATA already high at reset release starts a frame of the cleared holding word
        do_reset("rst_hi", 1'b1);
        idle(3, 1'b1);
        idle(45, 1'b0);

        // random traffic
        t = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            ld = ($urandom_range(0, 9) == 0);
            d  = W'($urandom);
            if ($urandom_range(0, 5) == 0) t = ~t;
            drive(ld, d, t);
        end
        idle(50, 1'b0);

        chk("queue_drained", 64'(expq.size()), 64'd0);
        chk("frame_count", 64'(frames_seen), 64'(frames_exp));
        chk("load_ign_pulses", 64'(ign_seen), 64'(m_ign));
        chk("idle_line_and_busy", 64'(idle_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
